// File: rtl/raw_bypass_pkg.sv
// Shared types and constants for the RAW bypass / hazard unit.
// Holds the tracker-entry layout, register-index width and fwd_sel encodings.
package raw_bypass_pkg;

  localparam int REG_W = 5;

  // fwd_sel = FWD_SEL_RF selects the register file; FWD_SEL_STAGE0 + i selects stage i
  localparam int FWD_SEL_RF     = 0;
  localparam int FWD_SEL_STAGE0 = 1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '{valid: 1'b0, rd: 5'd0, we: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/raw_bypass_unit_resolve.sv
// Per-read-port resolver: youngest-first match against the tracker,
// operand select and not-ready detection for the winning producer.
module raw_port_resolve
  import raw_bypass_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH) + 1
) (
  input  logic [REG_W-1:0]            i_rs_addr,
  input  logic [XLEN-1:0]             i_rf_data,
  input  trk_entry_t [DEPTH-1:0]      i_entries,
  input  logic [DEPTH-1:0][XLEN-1:0]  i_stage_result,
  input  logic [DEPTH-1:0]            i_stage_result_valid,
  output logic [XLEN-1:0]             o_data,
  output logic [SELW-1:0]             o_fwd_sel,
  output logic                        o_not_ready
);

  // Scan oldest to youngest so the lowest matching index is the final winner
  always_comb begin
    o_data      = i_rf_data;
    o_fwd_sel   = SELW'(FWD_SEL_RF);
    o_not_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_entries[i].valid && i_entries[i].we &&
          (i_entries[i].rd != 5'd0) && (i_entries[i].rd == i_rs_addr)) begin
        o_data      = i_stage_result[i];
        o_fwd_sel   = SELW'(FWD_SEL_STAGE0 + i);
        o_not_ready = ~i_stage_result_valid[i] |
                      (i_entries[i].is_load & ~i_stage_result_valid[i]);
      end else begin
        o_data      = o_data;
      end
    end
  end

endmodule

// File: rtl/raw_bypass_unit.sv
// RAW hazard tracker: shifts ID instruction metadata down DEPTH stages,
// forwards operands per read port and raises a stall when a producer is not ready.
module raw_bypass_unit
  import raw_bypass_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  localparam int SELW = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic [REG_W-1:0]            issue_rd,
  input  logic                        issue_is_load,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [NRD-1:0][REG_W-1:0]   rs_addr,
  input  logic [NRD-1:0][XLEN-1:0]    rf_data,
  input  logic [DEPTH-1:0][XLEN-1:0]  stage_result,
  input  logic [DEPTH-1:0]            stage_result_valid,
  output logic [NRD-1:0][XLEN-1:0]    rs_data_out,
  output logic [NRD-1:0][SELW-1:0]    fwd_sel,
  output logic                        hazard_stall,
  output logic [31:0]                 stall_count
);

  trk_entry_t [DEPTH-1:0] r_entries;
  logic [31:0]            r_stall_count;
  logic [NRD-1:0]         w_not_ready;
  trk_entry_t             w_new_entry;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    raw_port_resolve #(
      .XLEN (XLEN),
      .DEPTH(DEPTH),
      .SELW (SELW)
    ) u_resolve (
      .i_rs_addr           (rs_addr[p]),
      .i_rf_data           (rf_data[p]),
      .i_entries           (r_entries),
      .i_stage_result      (stage_result),
      .i_stage_result_valid(stage_result_valid),
      .o_data              (rs_data_out[p]),
      .o_fwd_sel           (fwd_sel[p]),
      .o_not_ready         (w_not_ready[p])
    );
  end

  assign hazard_stall = issue_valid & (|w_not_ready) & ~flush;
  assign stall_count  = r_stall_count;

  always_comb begin
    if (issue_valid && !hazard_stall && !flush) begin
      w_new_entry = '{valid: 1'b1, rd: issue_rd, we: issue_we, is_load: issue_is_load};
    end else begin
      w_new_entry = TRK_BUBBLE;
    end
  end

  // Tracker shift and stall counter; the WB entry falls off the end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entries     <= {DEPTH{TRK_BUBBLE}};
      r_stall_count <= 32'd0;
    end else if (hold) begin
      r_entries     <= r_entries;
      r_stall_count <= r_stall_count;
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        r_entries[i] <= r_entries[i-1];
      end
      r_entries[0] <= w_new_entry;
      if (hazard_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
    end
  end

endmodule

// File: tb/tb_raw_bypass_unit.sv
// Directed bench for raw_bypass_unit: forwarding, load-use stall, hold,
// flush and reset behaviour with hand-computed expectations.
module tb_raw_bypass_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid, issue_we, issue_is_load, hold, flush;
  logic [4:0]        issue_rd;
  logic [1:0][4:0]   rs_addr;
  logic [1:0][31:0]  rf_data;
  logic [2:0][31:0]  stage_result;
  logic [2:0]        stage_result_valid;
  logic [1:0][31:0]  rs_data_out;
  logic [1:0][2:0]   fwd_sel;
  logic              hazard_stall;
  logic [31:0]       stall_count;

  int n_checks = 0;
  int n_errors = 0;

  raw_bypass_unit dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid       (issue_valid),
    .issue_we          (issue_we),
    .issue_rd          (issue_rd),
    .issue_is_load     (issue_is_load),
    .hold              (hold),
    .flush             (flush),
    .rs_addr           (rs_addr),
    .rf_data           (rf_data),
    .stage_result      (stage_result),
    .stage_result_valid(stage_result_valid),
    .rs_data_out       (rs_data_out),
    .fwd_sel           (fwd_sel),
    .hazard_stall      (hazard_stall),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
    issue_valid   = 1'b1;
    issue_rd      = rd;
    issue_we      = we;
    issue_is_load = ld;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0; issue_is_load = 1'b0;
    hold = 1'b0; flush = 1'b0;
    rs_addr = '0;
    stage_result_valid = 3'b111;
  endtask

  initial begin
    rf_data      = {32'hBBBB_0001, 32'hAAAA_0000};
    stage_result = {32'h0000_9999, 32'h0000_2222, 32'h0000_1111};
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("rst_sel0",   32'(fwd_sel[0]), 32'd0);
    check_val("rst_data1",  rs_data_out[1], 32'hBBBB_0001);
    check_val("rst_stall",  32'(hazard_stall), 32'd0);
    check_val("rst_count",  stall_count, 32'd0);

    // back-to-back ALU
    issue(5'd5, 1'b1, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0);
    rs_addr[0] = 5'd5;
    stage_result[0] = 32'h0000_1234;
    #1;
    check_val("alu_sel",   32'(fwd_sel[0]), 32'd1);
    check_val("alu_data",  rs_data_out[0], 32'h0000_1234);
    check_val("alu_stall", 32'(hazard_stall), 32'd0);
    tick();

    // load-use: exactly one stall, then forward from MEM
    rs_addr = '0;
    issue(5'd7, 1'b1, 1'b1);
    tick();
    issue(5'd0, 1'b0, 1'b0);
    rs_addr[1] = 5'd7;
    stage_result_valid = 3'b110;
    stage_result[1] = 32'h0000_ABCD;
    #1;
    check_val("lu_stall",  32'(hazard_stall), 32'd1);
    check_val("lu_sel_ex", 32'(fwd_sel[1]), 32'd1);
    tick();
    check_val("lu_sel_mem", 32'(fwd_sel[1]), 32'd2);
    check_val("lu_data",    rs_data_out[1], 32'h0000_ABCD);
    check_val("lu_nostall", 32'(hazard_stall), 32'd0);
    check_val("lu_count",   stall_count, 32'd1);
    tick();

    // multiple matches and x0 writer
    idle_inputs();
    stage_result[0] = 32'h0000_1111;
    issue(5'd3, 1'b1, 1'b0); tick();
    issue(5'd3, 1'b1, 1'b0); tick();
    issue(5'd0, 1'b0, 1'b0); issue_valid = 1'b0;
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd3;
    #1;
    check_val("mm_sel0",  32'(fwd_sel[0]), 32'd1);
    check_val("mm_data0", rs_data_out[0], 32'h0000_1111);
    check_val("mm_sel1",  32'(fwd_sel[1]), 32'd1);
    check_val("mm_data1", rs_data_out[1], 32'h0000_1111);
    rs_addr = '0;
    issue(5'd0, 1'b1, 1'b0); tick();
    issue_valid = 1'b0;
    #1;
    check_val("x0_sel",  32'(fwd_sel[0]), 32'd0);
    check_val("x0_data", rs_data_out[0], 32'hAAAA_0000);

    // WB same-cycle forwarding
    issue(5'd9, 1'b1, 1'b0); tick();
    issue_valid = 1'b0; tick(); tick();
    rs_addr[0] = 5'd9;
    #1;
    check_val("wb_sel",  32'(fwd_sel[0]), 32'd3);
    check_val("wb_data", rs_data_out[0], 32'h0000_9999);

    // hold during a load-use stall, then flush
    idle_inputs();
    issue(5'd7, 1'b1, 1'b1); tick();
    issue(5'd0, 1'b0, 1'b0);
    rs_addr[1] = 5'd7;
    stage_result_valid = 3'b110;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("hold_stall", 32'(hazard_stall), 32'd1);
      tick();
      check_val("hold_sel",   32'(fwd_sel[1]), 32'd1);
      check_val("hold_count", stall_count, 32'd1);
    end
    hold = 1'b0; flush = 1'b1;
    #1;
    check_val("flush_stall", 32'(hazard_stall), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_val("flush_bubble", 32'(fwd_sel[1]), 32'd2);
    check_val("flush_count",  stall_count, 32'd1);
    check_val("flush_nostall", 32'(hazard_stall), 32'd0);
    tick();

    // reset during an active stall
    idle_inputs();
    issue(5'd12, 1'b1, 1'b1); tick();
    issue(5'd0, 1'b0, 1'b0);
    rs_addr[0] = 5'd12;
    stage_result_valid = 3'b110;
    #1;
    check_val("rs_pre_stall", 32'(hazard_stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("rs_stall", 32'(hazard_stall), 32'd0);
    check_val("rs_sel",   32'(fwd_sel[0]), 32'd0);
    check_val("rs_data",  rs_data_out[0], 32'hAAAA_0000);
    check_val("rs_count", stall_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/raw_bypass_unit.md
RAW_BYPASS_UNIT -- requirements
Module: raw_bypass_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, default 32, data width.
- NRD, default 2, number of ID read ports.
- DEPTH, default 3, number of tracked post-ID stages: index 0 = EX, index DEPTH-1 = WB.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  ID holds a valid instruction.
- issue_we  in  1  ID instruction writes rd.
- issue_rd  in  5  ID destination register.
- issue_is_load  in  1  ID instruction is a load.
- hold  in  1  global pipeline freeze.
- flush  in  1  kill the ID instruction; insert a bubble into EX.
- rs_addr  in  NRD x 5  source register per read port.
- rf_data  in  NRD x XLEN  register-file read data per port.
- stage_result  in  DEPTH x XLEN  result bus per tracked stage.
- stage_result_valid  in  DEPTH  result on the bus is final.
- rs_data_out  out  NRD x XLEN  forwarded operand per port.
- fwd_sel  out  NRD x ($clog2(DEPTH)+1)  source per port: 0 = register file, i+1 = stage i.
- hazard_stall  out  1  ID must hold; a bubble enters EX.
- stall_count  out  32  count of cycles with hazard_stall asserted.

Function
REQ-003 The unit SHALL keep DEPTH tracker entries {valid, rd, we, is_load}; entry i mirrors the instruction in stage i.
REQ-004 An entry SHALL match port p when valid=1, we=1, rd!=0 and rd==rs_addr[p].
REQ-005 Match priority SHALL be youngest-first: the lowest matching index wins.
REQ-006 If no entry matches, or rs_addr[p]==0, then fwd_sel[p] SHALL be 0 and rs_data_out[p] SHALL equal rf_data[p].
REQ-007 If entry i wins for port p, fwd_sel[p] SHALL be i+1 and rs_data_out[p] SHALL equal stage_result[i], combinationally in the same cycle.
REQ-008 hazard_stall SHALL be 1 when issue_valid=1 and, for any port, the winning entry i has stage_result_valid[i]=0; otherwise it SHALL be 0.
REQ-009 hazard_stall SHALL be forced to 0 while flush=1.
REQ-010 If a load is in EX and stage_result_valid[0]=0, the consumer in ID SHALL see exactly one stall cycle, after which it SHALL forward from MEM.
REQ-011 Shift rule when hold=0:
- entry[i] <= entry[i-1] for i>=1.
- entry[0] <= {1, issue_rd, issue_we, issue_is_load} when issue_valid=1, hazard_stall=0 and flush=0.
- Otherwise entry[0] <= bubble (valid=0).
REQ-012 When hold=1, all entries and stall_count SHALL keep their values; outputs SHALL still be evaluated combinationally.
REQ-013 Priority order SHALL be rst, then hold, then flush, then normal shift.
REQ-014 The entry in stage DEPTH-1 SHALL be discarded on shift; a WB write and an ID read of the same register in the same cycle SHALL be satisfied by forwarding from stage DEPTH-1.
REQ-015 stall_count SHALL increment by 1 on each non-held cycle with hazard_stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-016 Ports with equal rs_addr SHALL resolve independently and identically.

Reset
REQ-017 On rst=1 at a clock edge:
- all entries SHALL become valid=0, rd=0, we=0, is_load=0.
- stall_count SHALL become 0.
REQ-018 In the cycle after reset, rs_data_out SHALL equal rf_data, fwd_sel SHALL be 0 and hazard_stall SHALL be 0.
REQ-019 A reset asserted mid-stall SHALL drop hazard_stall in the next cycle; no tracker entry SHALL survive reset.

Structure
REQ-020 A shared package SHALL hold:
- the tracker-entry struct typedef.
- the register-index width constant (5).
- the encodings for fwd_sel.
REQ-021 The unit SHALL instantiate one sub-module, raw_port_resolve, once per read port, performing match, priority, data select and not-ready detection.
REQ-022 The tracker shift register and stall_count SHALL live in raw_bypass_unit.

Verification
REQ-023 Bench SHALL cover:
- Back-to-back ALU: issue rd=5, then rs1=5 with stage_result[0]=32'h1234 valid -> fwd_sel[0]=1, rs_data_out[0]=32'h1234, no stall.
- Load-use: load rd=7, then rs2=7 with stage_result_valid[0]=0 -> hazard_stall=1 for one cycle; next cycle fwd_sel[1]=2, stall_count=1.
- Multiple matches: x3 in EX and MEM, both valid -> EX value selected; rs_addr=0 with an x0 writer in EX -> rf_data selected.
- WB same-cycle: rd=9 in stage DEPTH-1, rs1=9 -> rs_data_out[0]=stage_result[DEPTH-1].
- hold=1 for 3 cycles during a load-use stall -> entries and stall_count frozen; flush=1 -> hazard_stall=0 and a bubble enters EX.
- rst during an active stall -> all outputs revert to the REQ-018 values next cycle; stall_count=0.
